// File: rtl/nibble_acc_pkg.sv
// Shared types and defaults for the nibble accumulator: FSM state encoding,
// default widths and the single-bit full-adder cell used by the add stage.
`timescale 1ns/1ps
package nibble_acc_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int COUNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Returns {carry, sum}.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/nibble_add_stage.sv
// Combinational WIDTH-bit ripple adder built from full-adder cells, carry-in tied to 0.
`timescale 1ns/1ps
module nibble_add_stage
    import nibble_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign {carry[i+1], sum[i]} = full_adder(a[i], b[i], carry[i]);
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/nibble_accumulator.sv
// Framed streaming accumulator: sums operand beats through nibble_add_stage and
// presents one registered result per frame. Define ACC_SATURATE_EN to clamp at max instead of wrapping.
`timescale 1ns/1ps
module nibble_accumulator
    import nibble_acc_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    // Handshakes: a beat moves on a cycle where valid and ready are both high at the rising edge.
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   add_sum;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry;
    logic               ovf;
    logic               ovf_nxt;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;
    logic               accept;
    logic               handshake;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;
    assign base      = (state == IDLE) ? '0 : acc;

    nibble_add_stage #(.WIDTH(WIDTH)) u_add (
        .a         (base),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (carry)
    );

    always_comb begin
        acc_nxt = add_sum;
`ifdef ACC_SATURATE_EN
        // Once at max any nonzero operand carries out, so the clamp is self-sustaining.
        if (carry) acc_nxt = '1;
`else
        acc_nxt = add_sum;
`endif
        ovf_nxt   = ((state == IDLE) ? 1'b0 : ovf) | carry;
        count_nxt = (state == IDLE) ? COUNT_W'(1)
                  : ((count == COUNT_MAX) ? count : count + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
            HOLD:        if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // rst_n gating keeps the input closed while reset is asserted.
    always_comb begin
        in_ready  = rst_n & (state != HOLD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (accept) begin
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            count <= count_nxt;
            if (in_last) begin
                out_sum   <= acc_nxt;
                out_ovf   <= ovf_nxt;
                out_count <= count_nxt;
            end
        end else if (handshake) begin
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end
    end

endmodule
